// File: rtl/implication_monitor.sv
// Run-time checker for "antecedent |-> ##[MIN_DELAY:MAX_DELAY] consequent" on
// NUM_CHANNELS independent channels, with failure pulses, sticky flags and counters.
module implication_monitor #(
    parameter int NUM_CHANNELS = 4,
    parameter int MIN_DELAY    = 0,
    parameter int MAX_DELAY    = 1,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    clear,
    input  logic [NUM_CHANNELS-1:0] antecedent,
    input  logic [NUM_CHANNELS-1:0] consequent,
    output logic [NUM_CHANNELS-1:0] fail_pulse,
    output logic [NUM_CHANNELS-1:0] fail_sticky,
    output logic [COUNT_WIDTH-1:0]  pass_count,
    output logic [COUNT_WIDTH-1:0]  fail_count,
    output logic                    busy
);

    localparam int PW = (MAX_DELAY > 0) ? MAX_DELAY : 1;
    localparam int SW = COUNT_WIDTH + 6;
    localparam logic [SW-1:0] SAT = {6'b0, {COUNT_WIDTH{1'b1}}};

    generate
        if (NUM_CHANNELS < 1 || NUM_CHANNELS > 32 || MIN_DELAY < 0 ||
            MIN_DELAY > MAX_DELAY || MAX_DELAY > 31 || COUNT_WIDTH < 1) begin : g_bad_params
            $error("implication_monitor: illegal parameter combination");
        end
    endgenerate

    // Age-major storage: r_pend[k] holds, per channel, attempts started k+1 cycles ago.
    logic [NUM_CHANNELS-1:0] r_pend [PW];
    logic [NUM_CHANNELS-1:0] w_a    [MAX_DELAY+1];
    logic [NUM_CHANNELS-1:0] w_d    [MAX_DELAY+1];
    logic [NUM_CHANNELS-1:0] w_next [PW];

    logic [NUM_CHANNELS-1:0] w_fail;
    logic [NUM_CHANNELS-1:0] w_pass;
    logic                    w_busy_next;
    logic [5:0]              w_pass_pop;
    logic [5:0]              w_fail_pop;
    logic [SW-1:0]           w_pass_sum;
    logic [SW-1:0]           w_fail_sum;

    logic [NUM_CHANNELS-1:0] r_fail_pulse;
    logic [NUM_CHANNELS-1:0] r_fail_sticky;
    logic [COUNT_WIDTH-1:0]  r_pass_count;
    logic [COUNT_WIDTH-1:0]  r_fail_count;
    logic                    r_busy;

    genvar g;

    assign w_a[0] = antecedent & {NUM_CHANNELS{enable}};

    generate
        for (g = 1; g <= MAX_DELAY; g++) begin : g_age
            assign w_a[g] = r_pend[g-1];
        end

        for (g = 0; g <= MAX_DELAY; g++) begin : g_dis
            if (g >= MIN_DELAY) begin : g_win
                assign w_d[g] = w_a[g] & consequent;
            end else begin : g_early
                assign w_d[g] = '0;
            end
        end

        if (MAX_DELAY > 0) begin : g_state
            for (g = 0; g < MAX_DELAY; g++) begin : g_next
                assign w_next[g] = w_a[g] & ~w_d[g];
            end
        end else begin : g_nostate
            assign w_next[0] = '0;
        end
    endgenerate

    always_comb begin
        w_fail      = w_a[MAX_DELAY] & ~w_d[MAX_DELAY];
        w_pass      = '0;
        w_busy_next = 1'b0;
        w_pass_pop  = '0;
        w_fail_pop  = '0;
        for (int unsigned k = 0; k < MAX_DELAY + 1; k++) begin
            w_pass = w_pass | w_d[k];
        end
        for (int unsigned k = 0; k < PW; k++) begin
            w_busy_next = w_busy_next | (|w_next[k]);
        end
        for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            w_pass_pop = w_pass_pop + {5'b0, w_pass[c]};
            w_fail_pop = w_fail_pop + {5'b0, w_fail[c]};
        end
        // Sums are widened so a saturating compare is exact even for tiny counters.
        w_pass_sum = {6'b0, r_pass_count} + {{COUNT_WIDTH{1'b0}}, w_pass_pop};
        w_fail_sum = {6'b0, r_fail_count} + {{COUNT_WIDTH{1'b0}}, w_fail_pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < PW; k++) begin
                r_pend[k] <= '0;
            end
            r_fail_pulse  <= '0;
            r_fail_sticky <= '0;
            r_pass_count  <= '0;
            r_fail_count  <= '0;
            r_busy        <= 1'b0;
        end else if (clear) begin
            for (int unsigned k = 0; k < PW; k++) begin
                r_pend[k] <= '0;
            end
            r_fail_pulse  <= '0;
            r_fail_sticky <= '0;
            r_pass_count  <= '0;
            r_fail_count  <= '0;
            r_busy        <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < PW; k++) begin
                r_pend[k] <= w_next[k];
            end
            r_fail_pulse  <= w_fail;
            r_fail_sticky <= r_fail_sticky | w_fail;
            r_pass_count  <= (w_pass_sum > SAT) ? '1 : w_pass_sum[COUNT_WIDTH-1:0];
            r_fail_count  <= (w_fail_sum > SAT) ? '1 : w_fail_sum[COUNT_WIDTH-1:0];
            r_busy        <= w_busy_next;
        end
    end

    assign fail_pulse  = r_fail_pulse;
    assign fail_sticky = r_fail_sticky;
    assign pass_count  = r_pass_count;
    assign fail_count  = r_fail_count;
    assign busy        = r_busy;

endmodule

// File: tb/tb_implication_monitor.sv
// Bench for implication_monitor: four delay-window configurations driven in parallel,
// checked against hand-written vectors and an attempt-list reference model.
module tb_implication_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic       clr = 1'b0;
    logic [3:0] ante = '0;
    logic [3:0] cons = '0;

    always #5 clk = ~clk;

    logic [3:0]  pulse  [4];
    logic [3:0]  sticky [4];
    logic [15:0] pcnt   [4];
    logic [15:0] fcnt   [4];
    logic        busy   [4];
    logic [3:0]  p3, f3;
    logic [15:0] p0, f0, p1, f1, p2, f2;
    logic [3:0]  fp0, fp1, fp2, fp3, fs0, fs1, fs2, fs3;
    logic        b0, b1, b2, b3;

    implication_monitor #(.NUM_CHANNELS(4), .MIN_DELAY(0), .MAX_DELAY(0), .COUNT_WIDTH(16)) u0 (
        .clk(clk), .rst_n(rst_n), .enable(en), .clear(clr), .antecedent(ante), .consequent(cons),
        .fail_pulse(fp0), .fail_sticky(fs0), .pass_count(p0), .fail_count(f0), .busy(b0));
    implication_monitor #(.NUM_CHANNELS(4), .MIN_DELAY(1), .MAX_DELAY(1), .COUNT_WIDTH(16)) u1 (
        .clk(clk), .rst_n(rst_n), .enable(en), .clear(clr), .antecedent(ante), .consequent(cons),
        .fail_pulse(fp1), .fail_sticky(fs1), .pass_count(p1), .fail_count(f1), .busy(b1));
    implication_monitor #(.NUM_CHANNELS(4), .MIN_DELAY(1), .MAX_DELAY(3), .COUNT_WIDTH(16)) u2 (
        .clk(clk), .rst_n(rst_n), .enable(en), .clear(clr), .antecedent(ante), .consequent(cons),
        .fail_pulse(fp2), .fail_sticky(fs2), .pass_count(p2), .fail_count(f2), .busy(b2));
    implication_monitor #(.NUM_CHANNELS(4), .MIN_DELAY(2), .MAX_DELAY(3), .COUNT_WIDTH(4)) u3 (
        .clk(clk), .rst_n(rst_n), .enable(en), .clear(clr), .antecedent(ante), .consequent(cons),
        .fail_pulse(fp3), .fail_sticky(fs3), .pass_count(p3), .fail_count(f3), .busy(b3));

    assign pulse[0] = fp0;  assign sticky[0] = fs0;  assign pcnt[0] = p0;  assign fcnt[0] = f0;  assign busy[0] = b0;
    assign pulse[1] = fp1;  assign sticky[1] = fs1;  assign pcnt[1] = p1;  assign fcnt[1] = f1;  assign busy[1] = b1;
    assign pulse[2] = fp2;  assign sticky[2] = fs2;  assign pcnt[2] = p2;  assign fcnt[2] = f2;  assign busy[2] = b2;
    assign pulse[3] = fp3;  assign sticky[3] = fs3;  assign pcnt[3] = {12'b0, p3};  assign fcnt[3] = {12'b0, f3};  assign busy[3] = b3;

    int MINS [4] = '{0, 1, 1, 2};
    int MAXS [4] = '{0, 1, 3, 3};
    int CWS  [4] = '{16, 16, 16, 4};

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: each outstanding attempt is kept as its age in cycles.
    int         q [4][4][$];
    logic [3:0] e_pulse  [4];
    logic [3:0] e_sticky [4];
    int         e_pass   [4];
    int         e_fail   [4];
    logic       e_busy   [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_update();
        for (int m = 0; m < 4; m++) begin
            if (!rst_n) begin
                for (int c = 0; c < 4; c++) q[m][c].delete();
                e_pulse[m] = '0; e_sticky[m] = '0; e_pass[m] = 0; e_fail[m] = 0; e_busy[m] = 1'b0;
            end else begin
                int np, nf, sat;
                logic [3:0] fp;
                logic any;
                np = 0; nf = 0; fp = '0; any = 1'b0;
                sat = (1 << CWS[m]) - 1;
                for (int c = 0; c < 4; c++) begin
                    int nq[$];
                    logic passed, failed;
                    nq.delete(); passed = 1'b0; failed = 1'b0;
                    if (ante[c] && en) q[m][c].push_back(0);
                    foreach (q[m][c][i]) begin
                        int a;
                        a = q[m][c][i];
                        if (cons[c] && a >= MINS[m]) passed = 1'b1;
                        else if (a == MAXS[m]) failed = 1'b1;
                        else nq.push_back(a + 1);
                    end
                    if (clr) nq.delete();
                    q[m][c] = nq;
                    if (nq.size() != 0) any = 1'b1;
                    if (passed) np++;
                    if (failed) begin nf++; fp[c] = 1'b1; end
                end
                if (clr) begin
                    e_pulse[m] = '0; e_sticky[m] = '0; e_pass[m] = 0; e_fail[m] = 0;
                end else begin
                    e_pulse[m]  = fp;
                    e_sticky[m] = e_sticky[m] | fp;
                    e_pass[m]   = (e_pass[m] + np > sat) ? sat : e_pass[m] + np;
                    e_fail[m]   = (e_fail[m] + nf > sat) ? sat : e_fail[m] + nf;
                end
                e_busy[m] = any;
            end
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        for (int m = 0; m < 4; m++) begin
            chk($sformatf("m%0d.fail_pulse", m),  {28'b0, pulse[m]},  {28'b0, e_pulse[m]});
            chk($sformatf("m%0d.fail_sticky", m), {28'b0, sticky[m]}, {28'b0, e_sticky[m]});
            chk($sformatf("m%0d.pass_count", m),  {16'b0, pcnt[m]},   e_pass[m]);
            chk($sformatf("m%0d.fail_count", m),  {16'b0, fcnt[m]},   e_fail[m]);
            chk($sformatf("m%0d.busy", m),        {31'b0, busy[m]},   {31'b0, e_busy[m]});
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] c, input logic e, input logic cl);
        ante = a; cons = c; en = e; clr = cl;
        step();
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] c;
        logic       e;
        logic       cl;
        logic [3:0] pulse;
        logic [3:0] sticky;
        int         pass;
        int         fail;
    } vec_t;

    vec_t tbl [8];

    initial begin
        // Expected outputs of the MIN=MAX=0 instance, one cycle after each row is applied.
        tbl[0] = '{4'h1, 4'h0, 1'b1, 1'b0, 4'h1, 4'h1, 0, 1};
        tbl[1] = '{4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 4'h1, 0, 1};
        tbl[2] = '{4'h1, 4'h1, 1'b1, 1'b0, 4'h0, 4'h1, 1, 1};
        tbl[3] = '{4'h0, 4'h1, 1'b1, 1'b0, 4'h0, 4'h1, 1, 1};
        tbl[4] = '{4'h1, 4'h0, 1'b0, 1'b0, 4'h0, 4'h1, 1, 1};
        tbl[5] = '{4'hF, 4'h0, 1'b1, 1'b0, 4'hF, 4'hF, 1, 5};
        tbl[6] = '{4'hF, 4'h0, 1'b1, 1'b1, 4'h0, 4'h0, 0, 0};
        tbl[7] = '{4'h3, 4'h1, 1'b1, 1'b0, 4'h2, 4'h2, 1, 1};

        rst_n = 1'b0;
        drive(4'h0, 4'h0, 1'b1, 1'b0);
        drive(4'h0, 4'h0, 1'b1, 1'b0);
        chk("reset.pass_count", {16'b0, p0}, 32'd0);
        chk("reset.busy", {31'b0, b2}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].a, tbl[i].c, tbl[i].e, tbl[i].cl);
            chk($sformatf("tbl%0d.pulse", i),  {28'b0, fp0}, {28'b0, tbl[i].pulse});
            chk($sformatf("tbl%0d.sticky", i), {28'b0, fs0}, {28'b0, tbl[i].sticky});
            chk($sformatf("tbl%0d.pass", i),   {16'b0, p0},  tbl[i].pass);
            chk($sformatf("tbl%0d.fail", i),   {16'b0, f0},  tbl[i].fail);
        end

        // MIN=MAX=1: next-cycle consequent passes; same-cycle-only consequent fails.
        drive(4'h0, 4'h0, 1'b1, 1'b1);
        drive(4'h1, 4'h0, 1'b1, 1'b0);
        chk("nov.busy1", {31'b0, b1}, 32'd1);
        drive(4'h0, 4'h1, 1'b1, 1'b0);
        chk("nov.pass", {16'b0, p1}, 32'd1);
        chk("nov.nofail", {16'b0, f1}, 32'd0);
        drive(4'h1, 4'h1, 1'b1, 1'b0);
        chk("nov.pulse0", {28'b0, fp1}, 32'd0);
        drive(4'h0, 4'h0, 1'b1, 1'b0);
        chk("nov.pulse1", {28'b0, fp1}, 32'd1);
        chk("nov.fail", {16'b0, f1}, 32'd1);

        // MIN=1, MAX=3: one consequent discharges three overlapping attempts.
        drive(4'h0, 4'h0, 1'b1, 1'b1);
        drive(4'h1, 4'h0, 1'b1, 1'b0);
        drive(4'h1, 4'h0, 1'b1, 1'b0);
        drive(4'h1, 4'h0, 1'b1, 1'b0);
        chk("win.busy_pre", {31'b0, b2}, 32'd1);
        drive(4'h0, 4'h1, 1'b1, 1'b0);
        chk("win.pass", {16'b0, p2}, 32'd1);
        chk("win.fail", {16'b0, f2}, 32'd0);
        chk("win.busy_post", {31'b0, b2}, 32'd0);

        // MIN=2, MAX=3 with 4-bit counters: early consequent ignored, fail count saturates.
        drive(4'h0, 4'h0, 1'b1, 1'b1);
        for (int r = 0; r < 21; r++) begin
            drive(4'h1, 4'h0, 1'b1, 1'b0);
            drive(4'h0, 4'h1, 1'b1, 1'b0);
            drive(4'h0, 4'h0, 1'b1, 1'b0);
            if (r == 0) chk("sat.pulse_early", {28'b0, fp3}, 32'd0);
            drive(4'h0, 4'h0, 1'b1, 1'b0);
            if (r == 0) chk("sat.pulse", {28'b0, fp3}, 32'd1);
        end
        chk("sat.fail_count", {28'b0, f3}, 32'd15);

        // Reset mid-attempt discards it silently.
        drive(4'h0, 4'h0, 1'b1, 1'b1);
        drive(4'h1, 4'h0, 1'b1, 1'b0);
        chk("rst.busy_pre", {31'b0, b2}, 32'd1);
        ante = '0;
        rst_n = 1'b0;
        #1;
        chk("rst.busy_async", {31'b0, b2}, 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(4'h0, 4'h0, 1'b1, 1'b0);
            chk("rst.pulse2", {28'b0, fp2}, 32'd0);
            chk("rst.pulse3", {28'b0, fp3}, 32'd0);
        end
        chk("rst.busy", {31'b0, b3}, 32'd0);
        chk("rst.fcnt", {16'b0, f2}, 32'd0);

        // Disabled antecedent starts nothing.
        drive(4'h1, 4'h0, 1'b0, 1'b0);
        chk("dis.busy", {31'b0, b2}, 32'd0);
        chk("dis.pulse", {28'b0, fp0}, 32'd0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            drive(4'($urandom), 4'($urandom), ($urandom_range(0, 9) != 0), ($urandom_range(0, 99) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/implication_monitor.md
Name: implication_monitor

Overview:
- Synthesizable run-time checker for the windowed implication "antecedent |-> ##[MIN_DELAY:MAX_DELAY] consequent", replicated over NUM_CHANNELS independent channels.
- Generalises the fixed overlapping (MIN_DELAY=MAX_DELAY=0) and non-overlapping (MIN_DELAY=MAX_DELAY=1) checks to any delay window.
- Tracks every outstanding attempt and reports per-channel failure pulses, sticky flags and saturating pass/fail counters.
- Sits beside a DUT in formal and simulation benches; also usable as an on-silicon protocol watchdog.

Parameters:
- NUM_CHANNELS, 4, number of independent antecedent/consequent pairs (1..32).
- MIN_DELAY, 0, earliest cycle, relative to the antecedent, at which the consequent satisfies it.
- MAX_DELAY, 1, latest such cycle. MIN_DELAY <= MAX_DELAY <= 31; any other value is an elaboration error.
- COUNT_WIDTH, 16, width of the pass/fail counters.

Ports:
- clk  input  1  sole clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  when 0, new antecedents are ignored; pending attempts still resolve.
- clear  input  1  synchronous clear of pending attempts, sticky flags and counters.
- antecedent  input  NUM_CHANNELS  per-channel trigger, sampled at posedge.
- consequent  input  NUM_CHANNELS  per-channel response, sampled at posedge.
- fail_pulse  output  NUM_CHANNELS  1-cycle pulse per failed channel.
- fail_sticky  output  NUM_CHANNELS  set on failure, held until clear or reset.
- pass_count  output  COUNT_WIDTH  saturating count of channel-pass events.
- fail_count  output  COUNT_WIDTH  saturating count of channel-fail events.
- busy  output  1  any attempt outstanding on any channel.

Behaviour:
- Reset (rst_n=0): pending vectors, fail_pulse, fail_sticky, pass_count, fail_count and busy all go to 0 immediately.
- Reset mid-operation discards outstanding attempts with no failure reported.
- Per-channel state: age vector P[0..MAX_DELAY-1]. P[k]=1 means an attempt started k+1 cycles ago is outstanding. No state when MAX_DELAY=0.
- Current-cycle view per channel: A[0] = antecedent & enable; A[k] = P[k-1] for 1 <= k <= MAX_DELAY.
- Discharge: D[k] = A[k] & consequent & (k >= MIN_DELAY).
  - One consequent discharges every attempt whose window contains the current cycle.
  - Overlapping attempts are independent, matching SVA semantics.
- Failure: F = A[MAX_DELAY] & ~D[MAX_DELAY].
- Next state: P[k] <= A[k] & ~D[k] for k < MAX_DELAY. Attempts older than MAX_DELAY cease to exist.
- Consequents that discharge nothing are ignored. Neither an early consequent (k < MIN_DELAY) nor a vacuous cycle is an error.
- Channel pass event = any D[k] set. Channel fail event = F.
- Registered outputs, latency 1:
  - fail_pulse[c] <= F[c].
  - fail_sticky[c] <= fail_sticky[c] | F[c].
  - pass_count increments by popcount of pass events across channels.
  - fail_count increments by popcount of fail events across channels.
  - Both counters saturate at all-ones and never wrap.
- A channel may pass and fail in the same cycle when different attempts resolve differently; both counters increment.
- busy is registered: 1 iff any P bit is set after the update.
- clear=1: all P, fail_sticky, counters and fail_pulse go to 0 at the next edge.
  - Evaluation results of that same cycle are discarded; clear wins over simultaneous events.
- enable=0 affects only A[0]. Attempts already in flight still pass or fail.
- MIN_DELAY=MAX_DELAY=0: purely combinational check, registered one cycle later.

Test Plan:
- MIN=MAX=0, ch0: antecedent=1 with consequent=0 at cycle 5 -> fail_pulse[0]=1 at cycle 6, fail_sticky[0]=1, fail_count=1. Antecedent+consequent at cycle 8 -> pass_count=1 at cycle 9.
- MIN=MAX=1: antecedent at cycle 3, consequent at cycle 4 -> pass_count=1 at cycle 5, no fail. Antecedent at cycle 10, consequent at cycle 10 only -> fail_pulse[0] at cycle 12.
- MIN=1, MAX=3: antecedents at cycles 0,1,2; single consequent at cycle 3 -> all three discharged, pass_count=1, no fail, busy=0 at cycle 4.
- MIN=2, MAX=3: antecedent at cycle 0, consequent only at cycle 1 -> fail_pulse at cycle 4. Repeat 2^COUNT_WIDTH+5 times with COUNT_WIDTH=4 -> fail_count holds at 15.
- All 4 channels fail in the same cycle -> fail_count += 4, fail_sticky=4'hF. Clear asserted together with another failing cycle -> counters and stickies are 0 next cycle, no pulse.
- Antecedent at cycle 0 (MAX=3), rst_n low at cycle 1 for 1 cycle, then consequent never arrives -> no fail_pulse, busy=0, counters 0. Same with enable=0 at cycle 0 -> no attempt started.
